// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the seven-segment result display: FSM encoding,
// active-low glyph constants (bit6=a .. bit0=g) and the conversion length.
package seg_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH_0   = 7'b0000001;
    localparam logic [6:0] GLYPH_1   = 7'b1001111;
    localparam logic [6:0] GLYPH_2   = 7'b0010010;
    localparam logic [6:0] GLYPH_3   = 7'b0000110;
    localparam logic [6:0] GLYPH_4   = 7'b1001100;
    localparam logic [6:0] GLYPH_5   = 7'b0100100;
    localparam logic [6:0] GLYPH_6   = 7'b0100000;
    localparam logic [6:0] GLYPH_7   = 7'b0001111;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_ITER = 8;
    localparam int ITER_W   = $clog2(NUM_ITER);

endpackage

// File: rtl/seg_display_driver_seg7.sv
// Combinational BCD-to-glyph decoder; non-decimal codes and blank give all-off.
module seg7_decode
    import seg_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = GLYPH_0;
                4'd1:    seg = GLYPH_1;
                4'd2:    seg = GLYPH_2;
                4'd3:    seg = GLYPH_3;
                4'd4:    seg = GLYPH_4;
                4'd5:    seg = GLYPH_5;
                4'd6:    seg = GLYPH_6;
                4'd7:    seg = GLYPH_7;
                4'd8:    seg = GLYPH_8;
                4'd9:    seg = GLYPH_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_driver.sv
// Converts an 8-bit result to BCD with a sequential double-dabble and scans it
// onto a three-digit multiplexed display with leading-zero blanking.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] returnValue,
    input  logic       overflow,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);

    state_t            state_reg;
    logic [7:0]        bin_reg;
    logic [11:0]       bcd_reg;
    logic [ITER_W-1:0] iter_reg;
    logic              flag_reg;
    logic [11:0]       disp_bcd_reg;
    logic              disp_ovf_reg;
    logic [CW-1:0]     refresh_reg;
    logic [1:0]        digit_idx_reg;
    logic [7:0]        bcd_adj;

    // Only ones and tens need the +3 correction: for an 8-bit input the
    // hundreds nibble never exceeds 1 before a shift, so it never reaches 5.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            flag_reg     <= 1'b0;
            disp_bcd_reg <= '0;
            disp_ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        bin_reg   <= returnValue;
                        flag_reg  <= overflow;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        state_reg <= CONVERT;
                        busy      <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcd_reg  <= {bcd_reg[10:8], bcd_adj, bin_reg[7]};
                    bin_reg  <= {bin_reg[6:0], 1'b0};
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == ITER_W'(NUM_ITER - 1)) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_bcd_reg <= bcd_reg;
                    disp_ovf_reg <= flag_reg;
                    state_reg    <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    logic [3:0] nibble_sel;
    logic       blank_sel;
    logic [2:0] an_next;
    logic [6:0] glyph;

    always_comb begin
        nibble_sel = disp_bcd_reg[3:0];
        blank_sel  = 1'b0;
        an_next    = 3'b110;
        case (digit_idx_reg)
            2'd1: begin
                nibble_sel = disp_bcd_reg[7:4];
                blank_sel  = (disp_bcd_reg[11:8] == 4'd0) && (disp_bcd_reg[7:4] == 4'd0);
                an_next    = 3'b101;
            end
            2'd2: begin
                nibble_sel = disp_bcd_reg[11:8];
                blank_sel  = (disp_bcd_reg[11:8] == 4'd0);
                an_next    = 3'b011;
            end
            default: begin
                nibble_sel = disp_bcd_reg[3:0];
                blank_sel  = 1'b0;
                an_next    = 3'b110;
            end
        endcase
    end

    seg7_decode u_decode (
        .digit (nibble_sel),
        .blank (blank_sel),
        .seg   (glyph)
    );

    // an, seg and dp are registered together so they always describe one slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_reg   <= '0;
            digit_idx_reg <= 2'd0;
            an            <= 3'b110;
            seg           <= GLYPH_0;
            dp            <= 1'b1;
        end else begin
            if (refresh_reg == CW'(REFRESH_DIV - 1)) begin
                refresh_reg   <= '0;
                digit_idx_reg <= (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            an  <= an_next;
            seg <= glyph;
            dp  <= !((digit_idx_reg == 2'd0) && disp_ovf_reg);
        end
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, giving clock cycles per digit slot (minimum 2).
REQ-002 SHALL have ports: clk  in  1  single system clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: returnValue  in  8  unsigned result from the arithmetic stage.
REQ-005 SHALL have ports: overflow  in  1  overflow/remainder flag from the arithmetic stage.
REQ-006 SHALL have ports: load  in  1  one-cycle strobe requesting capture of returnValue and overflow.
REQ-007 SHALL have ports: busy  out  1  high while a conversion is in progress.
REQ-008 SHALL have ports: seg  out  7  active-low segments, bit6=a through bit0=g.
REQ-009 SHALL have ports: dp  out  1  active-low decimal point.
REQ-010 SHALL have ports: an  out  3  active-low one-hot digit enable: bit0 ones, bit1 tens, bit2 hundreds.

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT and COMMIT; the reset state is IDLE.
REQ-012 In IDLE, load=1 SHALL capture returnValue into a shift register and overflow into a flag, clear the BCD accumulator, and enter CONVERT.
REQ-013 CONVERT SHALL run exactly 8 sequential double-dabble iterations, one per cycle: add 3 to each BCD nibble >=5, then shift left one bit taking in the binary MSB.
REQ-014 After the 8th iteration the FSM SHALL enter COMMIT.
REQ-015 COMMIT SHALL copy the 12-bit BCD result and the captured flag into the display registers, then return to IDLE.
REQ-016 busy SHALL be 1 in CONVERT and COMMIT, and 0 in IDLE.
REQ-017 Latency: with load at edge N, the display registers SHALL update at edge N+9 and busy SHALL fall at N+9.
REQ-018 load asserted while busy=1 SHALL be ignored, with no queuing.
REQ-019 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-020 On wrap, the digit index SHALL advance ones->tens->hundreds->ones.
REQ-021 an SHALL be the registered active-low one-hot of the digit index.
REQ-022 seg SHALL be the registered active-low glyph of the selected BCD nibble (0-9).
REQ-023 Leading-zero blanking: the hundreds digit SHALL be blank (seg=7'h7F) when hundreds=0.
REQ-024 Leading-zero blanking: the tens digit SHALL be blank when hundreds=0 and tens=0.
REQ-025 The ones digit SHALL never be blanked.
REQ-026 dp SHALL be 0 (lit) only while the ones digit is selected and the displayed overflow flag is 1; otherwise dp SHALL be 1.
REQ-027 Scanning SHALL continue uninterrupted during conversion; the old value SHALL remain displayed until COMMIT.
REQ-028 Display-register update and glyph selection in the same cycle SHALL use the pre-update value; the new value SHALL appear from the next cycle.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set: FSM=IDLE, busy=0, refresh counter=0, digit index=ones, BCD and display registers=0, overflow flags=0.
REQ-030 Reset outputs SHALL be an=3'b110, seg=7'b0000001 (glyph "0"), dp=1.
REQ-031 Reset mid-conversion SHALL abort the conversion; no partial result SHALL reach the display.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the ten segment-glyph constants, the blank constant and the iteration count (8).
REQ-033 A single combinational sub-module seg7_decode SHALL be used (4-bit BCD plus blank in, 7-bit active-low seg out); all other logic SHALL be in seg_display_driver.

Verification
REQ-034 Reset: rst_n low, then high -> an=110, seg=0000001, dp=1, busy=0.
REQ-035 Conversion: load with returnValue=8'd255, overflow=0 -> busy high 8 cycles plus COMMIT; digits 2,5,5 on hundreds/tens/ones; dp=1 throughout.
REQ-036 Blanking: returnValue=8'd7 -> hundreds and tens seg=1111111, ones seg=0001111; returnValue=8'd40 -> hundreds blank, tens "4", ones "0".
REQ-037 Overflow: returnValue=8'd12, overflow=1 -> dp=0 only while an=110.
REQ-038 Busy load: load 8'd99, then load 8'd5 three cycles later -> "99" displayed and 5 ignored.
REQ-039 Mid-conversion reset: reset during CONVERT after a prior display of 8'd123 -> display reads "0"; the next load of 8'd64 converts correctly to "64".
